// File: rtl/fir_mac_sequencer_pkg.sv
// fir_seq_pkg: shared FSM state type, default tap table
// and accumulator width helper for fir_mac_sequencer.
package fir_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DRAIN
  } state_t;

  localparam int DEF_N = 16;

  localparam int DEF_COEF [DEF_N] = '{
    311, 469, 917, 1582,
    2352, 3091, 3671, 3990,
    3990, 3671, 3091, 2352,
    1582, 917, 469, 311
  };

  function automatic int acc_w(
    input int w,
    input int c,
    input int n
  );
    return w + c + $clog2(n);
  endfunction

  // Larger tap counts repeat the table.
  function automatic int def_coef(input int k);
    return DEF_COEF[k % DEF_N];
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample/coef/result bundle of fir_mac_sequencer.
// master: upstream + sink side, slave: the filter.
interface fir_mac_sequencer_if
  import fir_seq_pkg::*;
#(
  parameter int N_TAPS = 16,
  parameter int WIDTH  = 14,
  parameter int COEF_W = 16
);
  localparam int AW    = $clog2(N_TAPS);
  localparam int ACC_W = acc_w(WIDTH, COEF_W, N_TAPS);

  logic                     din_valid;
  logic                     din_ready;
  logic signed [WIDTH-1:0]  din;
  logic                     coef_wr_en;
  logic [AW-1:0]            coef_wr_addr;
  logic signed [COEF_W-1:0] coef_wr_data;
  logic                     coef_swap;
  logic                     coef_swap_pend;
  logic                     dout_valid;
  logic signed [ACC_W-1:0]  dout;
  logic                     busy;
  logic [7:0]               overrun_cnt;

  modport master (
    output din_valid, din,
    output coef_wr_en, coef_wr_addr,
    output coef_wr_data, coef_swap,
    input  din_ready, coef_swap_pend,
    input  dout_valid, dout,
    input  busy, overrun_cnt
  );

  modport slave (
    input  din_valid, din,
    input  coef_wr_en, coef_wr_addr,
    input  coef_wr_data, coef_swap,
    output din_ready, coef_swap_pend,
    output dout_valid, dout,
    output busy, overrun_cnt
  );

endinterface

// File: rtl/fir_mac_sequencer_coef_bank.sv
// fir_coef_bank: shadow/active tap banks, swap pending.
// Ports: wr port, swap req, idle, tap read, pend flag.
module fir_coef_bank
  import fir_seq_pkg::*;
#(
  parameter int N_TAPS = 16,
  parameter int COEF_W = 16
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [$clog2(N_TAPS)-1:0]  i_wr_addr,
  input  logic signed [COEF_W-1:0]   i_wr_data,
  input  logic                       i_swap,
  input  logic                       i_idle,
  input  logic [$clog2(N_TAPS)-1:0]  i_rd_addr,
  output logic signed [COEF_W-1:0]   o_rd_data,
  output logic                       o_pend
);

  logic signed [COEF_W-1:0] r_shadow [N_TAPS];
  logic signed [COEF_W-1:0] r_active [N_TAPS];
  logic                     r_pend;

  // The copy reads shadow before this edge's write,
  // and active only moves while the sequencer idles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        r_shadow[i] <= COEF_W'(def_coef(i));
        r_active[i] <= COEF_W'(def_coef(i));
      end
      r_pend <= 1'b0;
    end else begin
      if (i_wr_en) begin
        r_shadow[i_wr_addr] <= i_wr_data;
      end
      if (i_idle && (i_swap || r_pend)) begin
        for (int i = 0; i < N_TAPS; i++) begin
          r_active[i] <= r_shadow[i];
        end
        r_pend <= 1'b0;
      end else if (i_swap) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign o_rd_data = r_active[i_rd_addr];
  assign o_pend    = r_pend;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one MAC walks N_TAPS taps/sample.
// Ports: clk, rst (sync, high), bus (slave modport).
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int N_TAPS = 16,
  parameter int WIDTH  = 14,
  parameter int COEF_W = 16
)(
  input  logic              clk,
  input  logic              rst,
  fir_mac_sequencer_if.slave bus
);

  localparam int AW    = $clog2(N_TAPS);
  localparam int PW    = WIDTH + COEF_W;
  localparam int ACC_W = acc_w(WIDTH, COEF_W, N_TAPS);

  localparam logic [AW-1:0] K_ONE = AW'(1);
  localparam logic [AW-1:0] K_MAX = AW'(N_TAPS - 1);

  state_t                   r_state;
  logic signed [WIDTH-1:0]  r_ring [N_TAPS];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_base;
  logic [AW-1:0]            r_k;
  logic signed [PW-1:0]     r_prod;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  r_dout;
  logic                     r_dout_vld;
  logic [7:0]               r_ovr;

  logic                     w_ready;
  logic                     w_pend;
  logic [AW-1:0]            w_idx;
  logic signed [WIDTH-1:0]  w_x;
  logic signed [COEF_W-1:0] w_c;
  logic signed [PW-1:0]     w_xe;
  logic signed [PW-1:0]     w_ce;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_pext;
  logic signed [ACC_W-1:0]  w_sum;

  fir_coef_bank #(
    .N_TAPS (N_TAPS),
    .COEF_W (COEF_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (bus.coef_wr_en),
    .i_wr_addr (bus.coef_wr_addr),
    .i_wr_data (bus.coef_wr_data),
    .i_swap    (bus.coef_swap),
    .i_idle    (r_state == IDLE),
    .i_rd_addr (r_k),
    .o_rd_data (w_c),
    .o_pend    (w_pend)
  );

  assign w_ready = (r_state == IDLE) && !rst;

  // Index wraps mod N_TAPS: tap k sees x[n-k].
  assign w_idx  = r_base - r_k;
  assign w_x    = r_ring[w_idx];
  assign w_xe   = {{COEF_W{w_x[WIDTH-1]}}, w_x};
  assign w_ce   = {{WIDTH{w_c[COEF_W-1]}}, w_c};
  assign w_prod = w_xe * w_ce;
  assign w_pext = {{AW{r_prod[PW-1]}}, r_prod};
  assign w_sum  = r_acc + w_pext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      for (int i = 0; i < N_TAPS; i++) begin
        r_ring[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_base     <= '0;
      r_k        <= '0;
      r_prod     <= '0;
      r_acc      <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_ovr      <= '0;
    end else begin
      r_dout_vld <= 1'b0;
      if (bus.din_valid && !w_ready
          && r_ovr != 8'hFF) begin
        r_ovr <= r_ovr + 8'd1;
      end
      unique case (r_state)
        IDLE: begin
          if (bus.din_valid) begin
            r_ring[r_wr_ptr] <= bus.din;
            r_base   <= r_wr_ptr;
            r_wr_ptr <= r_wr_ptr + K_ONE;
            r_k      <= '0;
            r_state  <= MAC;
          end
        end
        MAC: begin
          r_prod <= w_prod;
          r_k    <= r_k + K_ONE;
          // Product of tap k lands in acc one cycle later;
          // the first one loads rather than adds.
          if (r_k == K_ONE) begin
            r_acc <= w_pext;
          end else if (r_k != '0) begin
            r_acc <= w_sum;
          end
          if (r_k == K_MAX) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_acc      <= w_sum;
          r_dout     <= w_sum;
          r_dout_vld <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.din_ready      = w_ready;
  assign bus.coef_swap_pend = w_pend;
  assign bus.dout_valid     = r_dout_vld;
  assign bus.dout           = r_dout;
  assign bus.busy           = (r_state != IDLE);
  assign bus.overrun_cnt    = r_ovr;

endmodule
